// File: rtl/dm_ahb_pkg.sv
// rtl/dm_ahb_pkg.sv - shared AHB-Lite codes and FSM state type for the data-memory bridge
package dm_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_lane_decode.sv
// rtl/dm_lane_decode.sv - byte-lane select to HSIZE / HADDR[1:0] decode
//
// Ports:
//   sel_i      byte-lane enables from the core
//   hsize_o    AHB transfer size
//   addr_lo_o  low two address bits for the transfer
// Unrecognised lane patterns fall back to an aligned word access.
module dm_lane_decode
    import dm_ahb_pkg::*;
(
    input  logic [3:0] sel_i,
    output logic [2:0] hsize_o,
    output logic [1:0] addr_lo_o
);

    always_comb begin
        hsize_o   = HSIZE_WORD;
        addr_lo_o = 2'b00;
        case (sel_i)
            4'b0001: begin hsize_o = HSIZE_BYTE; addr_lo_o = 2'd0; end
            4'b0010: begin hsize_o = HSIZE_BYTE; addr_lo_o = 2'd1; end
            4'b0100: begin hsize_o = HSIZE_BYTE; addr_lo_o = 2'd2; end
            4'b1000: begin hsize_o = HSIZE_BYTE; addr_lo_o = 2'd3; end
            4'b0011: begin hsize_o = HSIZE_HALF; addr_lo_o = 2'd0; end
            4'b1100: begin hsize_o = HSIZE_HALF; addr_lo_o = 2'd2; end
            default: begin hsize_o = HSIZE_WORD; addr_lo_o = 2'd0; end
        endcase
    end

endmodule

// File: rtl/dm_ahb_bridge.sv
// rtl/dm_ahb_bridge.sv - uRV data-memory port to single AHB-Lite master transfers
//
// Ports:
//   wclk, rst            clock, asynchronous active-low reset
//   dm_*_i / dm_*_o      core data-memory request / response interface
//   H*                   AHB-Lite master signals (HBURST=SINGLE, HMASTLOCK=0)
// Build option: DM_AHB_WBUF_EN adds a one-entry posted write buffer
// (stores acknowledged the cycle after acceptance; bus write errors
// then raise only dm_bus_err_o).
module dm_ahb_bridge
    import dm_ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_DEF = 4'b0011
) (
    input  logic        wclk,
    input  logic        rst,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_ready_o,
    output logic        dm_bus_err_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

`ifdef DM_AHB_WBUF_EN
    localparam bit WBUF_EN = 1'b1;
`else
    localparam bit WBUF_EN = 1'b0;
`endif

    dm_state_e   state_q, state_d;
    logic [31:0] haddr_q, hwdata_q, rdata_q;
    logic [2:0]  hsize_q;
    logic        hwrite_q;
    logic        load_done_q, store_done_q, bus_err_q;
    logic [2:0]  dec_size;
    logic [1:0]  dec_lo;
    logic        req, xfer_end, xfer_err;
    logic        unused_addr_lo;

    // The lane select alone determines the low address bits.
    assign unused_addr_lo = ^dm_addr_i[1:0];

    dm_lane_decode u_lane_decode (
        .sel_i     (dm_data_select_i),
        .hsize_o   (dec_size),
        .addr_lo_o (dec_lo)
    );

    assign req      = (state_q == ST_IDLE) && (dm_store_i || dm_load_i);
    // A transfer ends on HREADY in the data phase (OKAY, or a malformed
    // single-cycle ERROR) or on the second cycle of a two-cycle ERROR.
    assign xfer_end = HREADY && ((state_q == ST_DATA) || (state_q == ST_ERR));
    assign xfer_err = HRESP || (state_q == ST_ERR);

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_ADDR;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            ST_DATA: begin
                if (HREADY)     state_d = ST_IDLE;
                else if (HRESP) state_d = ST_ERR;
            end
            ST_ERR:  if (HREADY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HTRANS     = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        dm_ready_o = (state_q == ST_IDLE);
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            haddr_q      <= 32'd0;
            hwdata_q     <= 32'd0;
            rdata_q      <= 32'd0;
            hsize_q      <= HSIZE_WORD;
            hwrite_q     <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            if (req) begin
                // Store wins when both strobes are raised together.
                haddr_q      <= {dm_addr_i[31:2], dec_lo};
                hsize_q      <= dec_size;
                hwrite_q     <= dm_store_i;
                hwdata_q     <= dm_data_s_i;
                store_done_q <= WBUF_EN && dm_store_i;
            end
            if (xfer_end) begin
                bus_err_q <= xfer_err;
                if (!hwrite_q) begin
                    load_done_q <= 1'b1;
                    if (!xfer_err) rdata_q <= HRDATA;
                end else begin
                    // Posted stores were already acknowledged at acceptance.
                    store_done_q <= !WBUF_EN;
                end
            end
        end
    end

    assign dm_data_l_o     = rdata_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_err_o    = bus_err_q;
    assign HADDR           = haddr_q;
    assign HSIZE           = hsize_q;
    assign HWRITE          = hwrite_q;
    assign HWDATA          = hwdata_q;
    assign HBURST          = HBURST_SINGLE;
    assign HPROT           = HPROT_DEF;
    assign HMASTLOCK       = 1'b0;

endmodule

// File: tb/tb_dm_ahb_bridge.sv
// tb/tb_dm_ahb_bridge.sv - self-checking bench for dm_ahb_bridge
module tb_dm_ahb_bridge;

`ifdef DM_AHB_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        wclk = 1'b0;
    logic        rst  = 1'b0;
    logic [31:0] dm_addr_i = '0, dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_store_i = 1'b0, dm_load_i = 1'b0;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o, dm_store_done_o, dm_ready_o, dm_bus_err_o;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic        HWRITE, HMASTLOCK;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    always #5 wclk = ~wclk;

    dm_ahb_bridge dut (
        .wclk(wclk), .rst(rst),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .dm_ready_o(dm_ready_o),
        .dm_bus_err_o(dm_bus_err_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] slv_mem [16];   // bus-level slave memory
    logic [31:0] ref_mem [16];   // request-level reference memory
    logic [31:0] ref_ldata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected size / low address / byte mask from the lane-select rules:
    // one lane -> byte at that lane; an aligned adjacent pair -> halfword;
    // anything else -> aligned word.
    function automatic void exp_lane(input logic [3:0] sel, output logic [2:0] sz,
                                     output logic [1:0] lo, output logic [3:0] mask);
        int n;
        int low;
        n = $countones(sel);
        low = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
        if (n == 1) begin
            sz = 3'd0; lo = 2'(low); mask = sel;
        end else if (n == 2 && (low == 0 || low == 2) && sel[low+1]) begin
            sz = 3'd1; lo = 2'(low); mask = sel;
        end else begin
            sz = 3'd2; lo = 2'd0; mask = 4'hF;
        end
    endfunction

    task automatic garbage();
        dm_store_i       = 1'($urandom_range(0, 1));
        dm_load_i        = 1'($urandom_range(0, 1));
        dm_addr_i        = $urandom;
        dm_data_s_i      = $urandom;
        dm_data_select_i = 4'($urandom);
    endtask

    task automatic busy_pulses(input bit is_store, input int cyc);
        chk("store_done_busy", 32'(dm_store_done_o), 32'(WBUF && is_store && cyc == 1));
        chk("load_done_busy", 32'(dm_load_done_o), 32'd0);
        chk("bus_err_busy", 32'(dm_bus_err_o), 32'd0);
        chk("ready_busy", 32'(dm_ready_o), 32'd0);
    endtask

    task automatic tick();
        dm_store_i = 1'b0;
        dm_load_i  = 1'b0;
        @(negedge wclk);
        chk("idle_pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_err_o}), 32'd0);
    endtask

    // Called in the cycle the request is presented; returns in the done cycle.
    task automatic xfer(input bit st, input bit ld, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data,
                        input int aw, input int dw, input bit err);
        logic [2:0]  esz, s_size;
        logic [1:0]  elo;
        logic [3:0]  emask;
        logic [31:0] eaddr, s_addr;
        bit          is_store;
        int          cyc, nb, lo;
        is_store = st;
        exp_lane(sel, esz, elo, emask);
        eaddr = {addr[31:2], elo};
        s_addr = '0;
        s_size = '0;
        chk("ready_req", 32'(dm_ready_o), 32'd1);
        dm_store_i = st; dm_load_i = ld; dm_addr_i = addr;
        dm_data_select_i = sel; dm_data_s_i = data;
        HREADY = 1'b1; HRESP = 1'b0;
        cyc = 0;
        for (int i = 0; i <= aw; i++) begin
            @(negedge wclk); cyc++;
            garbage();
            busy_pulses(is_store, cyc);
            chk("htrans_addr", 32'(HTRANS), 32'h2);
            chk("haddr", HADDR, eaddr);
            chk("hsize", 32'(HSIZE), 32'(esz));
            chk("hwrite", 32'(HWRITE), 32'(is_store));
            chk("hburst", 32'(HBURST), 32'd0);
            chk("hprot", 32'(HPROT), 32'h3);
            chk("hmastlock", 32'(HMASTLOCK), 32'd0);
            HREADY = (i == aw);
            s_addr = HADDR; s_size = HSIZE;
        end
        for (int i = 0; i <= dw; i++) begin
            @(negedge wclk); cyc++;
            garbage();
            busy_pulses(is_store, cyc);
            chk("htrans_data", 32'(HTRANS), 32'h0);
            chk("haddr_hold", HADDR, eaddr);
            if (is_store) chk("hwdata", HWDATA, data);
            HRDATA = $urandom;
            if (i < dw) begin
                HREADY = 1'b0; HRESP = 1'b0;
            end else if (err) begin
                HREADY = 1'b0; HRESP = 1'b1;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                if (HWRITE) begin
                    nb = 1 << s_size;
                    lo = int'(s_addr[1:0]);
                    for (int b = 0; b < 4; b++)
                        if (b >= lo && b < lo + nb)
                            slv_mem[s_addr[5:2]][8*b +: 8] = HWDATA[8*b +: 8];
                end else begin
                    HRDATA = slv_mem[s_addr[5:2]];
                end
            end
        end
        if (err) begin
            @(negedge wclk); cyc++;
            garbage();
            busy_pulses(is_store, cyc);
            chk("htrans_err", 32'(HTRANS), 32'h0);
            HREADY = 1'b1; HRESP = 1'b1;
        end
        @(negedge wclk);
        dm_store_i = 1'b0; dm_load_i = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        if (!err) begin
            if (is_store) begin
                for (int b = 0; b < 4; b++)
                    if (emask[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
            end else begin
                ref_ldata = ref_mem[addr[5:2]];
            end
        end
        chk("load_done", 32'(dm_load_done_o), 32'(!is_store));
        chk("store_done", 32'(dm_store_done_o), 32'(is_store && !WBUF));
        chk("bus_err", 32'(dm_bus_err_o), 32'(err));
        chk("load_data", dm_data_l_o, ref_ldata);
        chk("ready_done", 32'(dm_ready_o), 32'd1);
        chk("htrans_done", 32'(HTRANS), 32'h0);
    endtask

    initial begin
        int mode;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[0] = 32'hDEADBEEF;
        ref_mem[0] = 32'hDEADBEEF;

        @(negedge wclk);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'h2);
        chk("rst_hburst", 32'(HBURST), 32'h0);
        chk("rst_hprot", 32'(HPROT), 32'h3);
        chk("rst_ldata", dm_data_l_o, 32'h0);
        chk("rst_pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_err_o}), 32'd0);
        chk("rst_ready", 32'(dm_ready_o), 32'd1);
        rst = 1'b1;
        tick();

        xfer(1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'h0, 0, 0, 1'b0);
        chk("load_deadbeef", dm_data_l_o, 32'hDEADBEEF);
        tick();
        xfer(1'b1, 1'b0, 32'h0000_0010, 4'b0100, 32'h00AB_0000, 0, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'h0000_0024, 4'b0011, 32'h0, 0, 2, 1'b0);
        xfer(1'b1, 1'b0, 32'h0000_0030, 4'hF, 32'h1234_5678, 0, 0, 1'b1);
        xfer(1'b1, 1'b1, 32'h0000_0034, 4'b1100, 32'hCAFE_0000, 0, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'h0000_0034, 4'hF, 32'h0, 0, 0, 1'b0);
        tick();

        // Reset in the data phase of a load.
        dm_load_i = 1'b1; dm_addr_i = 32'h0000_0040; dm_data_select_i = 4'hF;
        HREADY = 1'b1;
        @(negedge wclk);
        dm_load_i = 1'b0;
        @(negedge wclk);
        HREADY = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mrst_htrans", 32'(HTRANS), 32'h0);
        chk("mrst_haddr", HADDR, 32'h0);
        chk("mrst_hsize", 32'(HSIZE), 32'h2);
        chk("mrst_ready", 32'(dm_ready_o), 32'd1);
        chk("mrst_ldata", dm_data_l_o, 32'h0);
        ref_ldata = '0;
        HREADY = 1'b1;
        @(negedge wclk);
        chk("mrst_pulses", 32'({dm_load_done_o, dm_store_done_o, dm_bus_err_o}), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        xfer(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0, 1, 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 2));
            xfer(mode != 0, mode != 1, $urandom, 4'($urandom),
                 $urandom, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
